// File: rtl/mult_share_arbiter_pkg.sv
// Shared types and constants for the multiplier-sharing arbiter.
// Optional feature macro: MULT_SHARE_ARBITER_TIMEOUT_EN (WAIT timeout with error response).
package mult_share_arbiter_pkg;

  localparam int DATA_W             = 16;
  localparam int NUM_REQ_DEF        = 4;
  localparam int TIMEOUT_CYCLES_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

endpackage

// File: rtl/mult_share_arbiter_if.sv
// Requester, multiplier and response signals of the multiplier-sharing arbiter.
// slave is the arbiter side; master is the requester/multiplier side.
interface mult_share_arbiter_if
  import mult_share_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF
);
  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [DATA_W*NUM_REQ-1:0] req_a;
  logic [DATA_W*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]        req_ready;

  logic                      mul_enable;
  logic signed [DATA_W-1:0]  mul_a;
  logic signed [DATA_W-1:0]  mul_b;
  logic signed [DATA_W-1:0]  mul_product;
  logic                      mul_done;

  logic                      rsp_valid;
  logic [IW-1:0]             rsp_id;
  logic signed [DATA_W-1:0]  rsp_product;
  logic                      rsp_error;
  logic                      busy;

  modport slave (
    input  req_valid, req_a, req_b, mul_product, mul_done,
    output req_ready, mul_enable, mul_a, mul_b,
           rsp_valid, rsp_id, rsp_product, rsp_error, busy
  );

  modport master (
    output req_valid, req_a, req_b, mul_product, mul_done,
    input  req_ready, mul_enable, mul_a, mul_b,
           rsp_valid, rsp_id, rsp_product, rsp_error, busy
  );

endinterface

// File: rtl/mult_share_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
// Returns a one-hot grant and its index; any_req flags a non-empty request vector.
module rr_priority_picker #(
  parameter int NUM_REQ = 4,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      idx,
  output logic               any_req
);

  logic [IW-1:0] cand;

  always_comb begin
    idx     = '0;
    any_req = 1'b0;
    cand    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IW'((int'(ptr) + i) % NUM_REQ);
      if (!any_req && req[cand]) begin
        any_req = 1'b1;
        idx     = cand;
      end
    end
    grant = any_req ? (NUM_REQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one fixed-point multiplier among NUM_REQ requesters.
// Define MULT_SHARE_ARBITER_TIMEOUT_EN to abort a WAIT lasting TIMEOUT_CYCLES with rsp_error=1.
module mult_share_arbiter
  import mult_share_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = NUM_REQ_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  mult_share_arbiter_if.slave  bus
);

  localparam int IW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("mult_share_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
  end

  state_t state, state_n;

  logic [NUM_REQ-1:0]       grant;
  logic [IW-1:0]            pick_idx;
  logic                     any_req;
  logic [IW-1:0]            rr_ptr;
  logic                     accept;
  logic                     done_ok;
  logic                     timeout;

  logic signed [DATA_W-1:0] a_arr [NUM_REQ];
  logic signed [DATA_W-1:0] b_arr [NUM_REQ];

  logic signed [DATA_W-1:0] op_a_p0;
  logic signed [DATA_W-1:0] op_b_p0;
  logic [IW-1:0]            op_id_p0;

  logic                     vld_p1;
  logic [IW-1:0]            rsp_id_p1;
  logic signed [DATA_W-1:0] rsp_prod_p1;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_split
    assign a_arr[g] = bus.req_a[g*DATA_W +: DATA_W];
    assign b_arr[g] = bus.req_b[g*DATA_W +: DATA_W];
  end

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_picker (
    .req     (bus.req_valid),
    .ptr     (rr_ptr),
    .grant   (grant),
    .idx     (pick_idx),
    .any_req (any_req)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    done_ok = 1'b0;
    case (state)
      ST_IDLE: begin
        if (any_req) begin
          accept  = 1'b1;
          state_n = ST_ISSUE;
        end
      end
      ST_ISSUE: state_n = ST_WAIT;
      ST_WAIT: begin
        if (bus.mul_done) begin
          done_ok = 1'b1;
          state_n = ST_IDLE;
        end else if (timeout) begin
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Accept stage: latch the granted operands and advance the round-robin pointer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr   <= '0;
      op_a_p0  <= '0;
      op_b_p0  <= '0;
      op_id_p0 <= '0;
    end else if (accept) begin
      rr_ptr   <= (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
      op_a_p0  <= a_arr[pick_idx];
      op_b_p0  <= b_arr[pick_idx];
      op_id_p0 <= pick_idx;
    end
  end

  // Response stage: result registered on the WAIT exit, presented in the first IDLE cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1      <= 1'b0;
      rsp_id_p1   <= '0;
      rsp_prod_p1 <= '0;
    end else begin
      vld_p1 <= done_ok | timeout;
      if (done_ok) begin
        rsp_id_p1   <= op_id_p0;
        rsp_prod_p1 <= bus.mul_product;
      end else if (timeout) begin
        rsp_id_p1   <= op_id_p0;
        rsp_prod_p1 <= '0;
      end
    end
  end

`ifdef MULT_SHARE_ARBITER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] tmo_cnt;
  logic             rsp_err_p1;

  // The exit decision is taken in the WAIT cycle that makes TIMEOUT_CYCLES in total
  assign timeout = (state == ST_WAIT) && !bus.mul_done &&
                   (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt    <= '0;
      rsp_err_p1 <= 1'b0;
    end else begin
      if (state == ST_ISSUE)     tmo_cnt <= '0;
      else if (state == ST_WAIT) tmo_cnt <= tmo_cnt + 1'b1;
      if (done_ok)      rsp_err_p1 <= 1'b0;
      else if (timeout) rsp_err_p1 <= 1'b1;
    end
  end

  assign bus.rsp_error = rsp_err_p1;
`else
  assign timeout       = 1'b0;
  assign bus.rsp_error = 1'b0;
`endif

  assign bus.req_ready   = (reset_n && state == ST_IDLE) ? grant : '0;
  assign bus.mul_enable  = (state == ST_ISSUE);
  assign bus.mul_a       = op_a_p0;
  assign bus.mul_b       = op_b_p0;
  assign bus.rsp_valid   = vld_p1;
  assign bus.rsp_id      = rsp_id_p1;
  assign bus.rsp_product = rsp_prod_p1;
  assign bus.busy        = (state != ST_IDLE);

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed self-checking bench for mult_share_arbiter with a 2-cycle model multiplier.
// Define MULT_SHARE_ARBITER_TIMEOUT_EN to also exercise the WAIT timeout path.
module tb_mult_share_arbiter;

  logic clk = 1'b0;
  logic reset_n;
  int   errors = 0;
  int   checks = 0;

  logic        spur;
  logic        withhold;
  logic [15:0] model_prod;
  logic        en_d1;
  logic        model_done;

  mult_share_arbiter_if #(.NUM_REQ(4)) bus ();

  mult_share_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Model multiplier: done two cycles after the enable pulse, unless withheld
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_d1      <= 1'b0;
      model_done <= 1'b0;
    end else begin
      en_d1      <= bus.mul_enable && !withhold;
      model_done <= en_d1;
    end
  end

  assign bus.mul_done    = model_done | spur;
  assign bus.mul_product = model_done ? model_prod : 16'h7777;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b);
    bus.req_valid[i]       = 1'b1;
    bus.req_a[i*16 +: 16]  = a;
    bus.req_b[i*16 +: 16]  = b;
  endtask

  task automatic clr_req(input int i);
    bus.req_valid[i] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int order [5];
    order = '{0, 1, 2, 3, 0};

    reset_n = 1'b0;
    spur = 1'b0; withhold = 1'b0; model_prod = 16'h0000;
    bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0;

    // Reset state, with requests present
    step();
    bus.req_valid = 4'hF;
    #1;
    chk("rst_busy",   bus.busy, 0);
    chk("rst_ready",  bus.req_ready, 0);
    chk("rst_en",     bus.mul_enable, 0);
    chk("rst_rsp",    bus.rsp_valid, 0);
    chk("rst_mul_a",  bus.mul_a, 0);
    chk("rst_prod",   bus.rsp_product, 0);
    bus.req_valid = '0;
    step();
    reset_n = 1'b1;
    step();

    // Single request from requester 2
    set_req(2, 16'h0100, 16'h0200);
    model_prod = 16'h0040;
    #1;
    chk("single_ready", bus.req_ready, 4'b0100);
    step(); clr_req(2);
    chk("single_en",    bus.mul_enable, 1);
    chk("single_a",     bus.mul_a, 16'h0100);
    chk("single_b",     bus.mul_b, 16'h0200);
    chk("single_busy",  bus.busy, 1);
    step();
    chk("single_en_off", bus.mul_enable, 0);
    chk("single_a_hold", bus.mul_a, 16'h0100);
    step();
    chk("single_rsp_early", bus.rsp_valid, 0);
    step();
    chk("single_rsp",   bus.rsp_valid, 1);
    chk("single_id",    bus.rsp_id, 2);
    chk("single_prod",  bus.rsp_product, 16'h0040);
    chk("single_err",   bus.rsp_error, 0);
    chk("single_idle",  bus.busy, 0);
    step();
    chk("single_rsp_pulse", bus.rsp_valid, 0);
    chk("single_prod_hold", bus.rsp_product, 16'h0040);

    // All four requesters continuously valid after reset
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    for (int i = 0; i < 4; i++) set_req(i, 16'(16'h0A00 + i), 16'(16'h0B00 + i));
    for (int g = 0; g < 5; g++) begin
      model_prod = 16'(16'h1000 + g);
      #1;
      chk("rr_grant", bus.req_ready, 32'd1 << order[g]);
      step();
      chk("rr_mul_a", bus.mul_a, 16'(16'h0A00 + order[g]));
      step();
      step();
      chk("rr_pending", bus.req_ready, 0);
      step();
      chk("rr_rsp_id",   bus.rsp_id, order[g]);
      chk("rr_rsp_prod", bus.rsp_product, 16'(16'h1000 + g));
      if (g == 4) bus.req_valid = '0;
    end

    // Pointer wrap: grant 3, then 0 and 3 pending -> 0 first
    set_req(3, 16'h0003, 16'h0003);
    #1;
    chk("wrap_grant3", bus.req_ready, 4'b1000);
    step();
    set_req(0, 16'h0000, 16'h0000);
    #1;
    chk("wrap_busy_ready", bus.req_ready, 0);
    step(); step(); step();
    chk("wrap_grant0", bus.req_ready, 4'b0001);
    step(); clr_req(0);
    step(); step(); step();
    chk("wrap_grant3b", bus.req_ready, 4'b1000);
    step(); clr_req(3);
    step(); step(); step();

    // Spurious mul_done in IDLE and in ISSUE
    spur = 1'b1;
    step();
    spur = 1'b0;
    #1;
    chk("spur_idle_rsp",  bus.rsp_valid, 0);
    chk("spur_idle_busy", bus.busy, 0);
    set_req(1, 16'h0011, 16'h0022);
    model_prod = 16'h0123;
    #1;
    chk("spur_grant1", bus.req_ready, 4'b0010);
    step(); clr_req(1);
    spur = 1'b1;
    chk("spur_issue_en", bus.mul_enable, 1);
    step();
    spur = 1'b0;
    #1;
    chk("spur_wait_busy", bus.busy, 1);
    chk("spur_wait_rsp",  bus.rsp_valid, 0);
    step();
    chk("spur_t3_rsp", bus.rsp_valid, 0);
    step();
    chk("spur_rsp",  bus.rsp_valid, 1);
    chk("spur_id",   bus.rsp_id, 1);
    chk("spur_prod", bus.rsp_product, 16'h0123);

    // Reset while in WAIT
    set_req(2, 16'h0202, 16'h0303);
    #1;
    chk("rstw_grant2", bus.req_ready, 4'b0100);
    step(); clr_req(2);
    step();
    #2;
    reset_n = 1'b0;
    #1;
    chk("rstw_busy",  bus.busy, 0);
    chk("rstw_en",    bus.mul_enable, 0);
    chk("rstw_mul_a", bus.mul_a, 0);
    step();
    reset_n = 1'b1;
    step();
    spur = 1'b1;
    step();
    spur = 1'b0;
    #1;
    chk("rstw_no_rsp", bus.rsp_valid, 0);
    set_req(0, 16'h0005, 16'h0006);
    set_req(3, 16'h0007, 16'h0008);
    model_prod = 16'h0abc;
    #1;
    chk("rstw_grant0", bus.req_ready, 4'b0001);
    step(); clr_req(0); clr_req(3);
    step(); step(); step();
    chk("rstw_rsp_id", bus.rsp_id, 0);

`ifdef MULT_SHARE_ARBITER_TIMEOUT_EN
    // Withheld mul_done: timeout after 16 WAIT cycles
    withhold = 1'b1;
    set_req(1, 16'h0101, 16'h0101);
    step(); clr_req(1);
    for (int k = 0; k < 16; k++) step();
    chk("tmo_busy_last", bus.busy, 1);
    chk("tmo_rsp_early", bus.rsp_valid, 0);
    step();
    chk("tmo_rsp",  bus.rsp_valid, 1);
    chk("tmo_err",  bus.rsp_error, 1);
    chk("tmo_prod", bus.rsp_product, 16'h0000);
    chk("tmo_id",   bus.rsp_id, 1);
    withhold = 1'b0;
    model_prod = 16'h0055;
    set_req(2, 16'h0002, 16'h0002);
    #1;
    chk("tmo_next_grant", bus.req_ready, 4'b0100);
    step(); clr_req(2);
    step(); step(); step();
    chk("tmo_next_rsp",  bus.rsp_valid, 1);
    chk("tmo_next_err",  bus.rsp_error, 0);
    chk("tmo_next_prod", bus.rsp_product, 16'h0055);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
